vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-003 SHALL have parameter H_BACK, default 48, back-porch pixels.
REQ-004 SHALL have parameter H_TOTAL, default 800, pixels per line.
REQ-005 SHALL have parameters V_ACTIVE 480, V_SYNC 2, V_BACK 33, V_TOTAL 525, the same quantities counted in lines.
REQ-006 SHALL have parameter SYNC_POL, default 0, sync active level; 0 means active-low.
REQ-007 SYS_CLK  in  1  system clock; the only clock.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 pix_en_i  in  1  pixel strobe; one pulse per incoming pixel.
REQ-010 hsync_i, vsync_i  in  1 each  incoming sync lines.
REQ-011 red_i, green_i, blue_i  in  4 each  incoming colour.
REQ-012 pix_valid_o  out  1  decoded active pixel present.
REQ-013 x_o, y_o  out  10 each  active-area coordinates.
REQ-014 rgb_o  out  16  RGB565 pixel.
REQ-015 frame_start_o  out  1  single-cycle pulse, coincident with the pixel at x=0, y=0.
REQ-016 locked_o  out  1  timing matches the parameters.
REQ-017 h_meas_o, v_meas_o  out  12 each  last measured line length in pixels and frame length in lines.
REQ-018 err_cnt_o  out  8  count of lock losses, saturating.

Function
REQ-019 Two register stages SHALL delay pix_en_i, the syncs and the RGB inputs together; all decoding SHALL use the delayed strobe, and counters SHALL hold on cycles where that strobe is low.
REQ-020 A leading edge SHALL be the inactive-to-active transition of a sync, judged on consecutive strobed samples.
REQ-021 hcnt SHALL be set to 0 on an hsync leading edge and SHALL otherwise increment per strobe, saturating at 4095.
REQ-022 On an hsync leading edge, h_meas_o SHALL load the previous hcnt+1.
REQ-023 vcnt SHALL increment on each hsync leading edge and saturate at 4095; on a vsync leading edge it SHALL be set to 0 and v_meas_o SHALL load the previous vcnt+1.
REQ-024 When hsync and vsync leading edges coincide, vcnt SHALL be set to 0 and SHALL NOT also increment, and hcnt SHALL be set to 0.
REQ-025 The active region SHALL be hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
REQ-026 In the active region, x_o SHALL equal hcnt-(H_SYNC+H_BACK) and y_o SHALL equal vcnt-(V_SYNC+V_BACK).
REQ-027 rgb_o SHALL equal {r,r[3],g,g[3:2],b,b[3]}.
REQ-028 pix_valid_o SHALL be high only on a strobed cycle, in the active region, with locked_o high.
REQ-029 The outputs for a pixel sampled on a strobe at cycle N SHALL appear at cycle N+3.
REQ-030 The lock FSM SHALL have states INIT, SEARCH, VERIFY and LOCKED, and every transition SHALL be evaluated at a vsync leading edge.
- INIT -> SEARCH on the first vsync edge, because the first frame measurement is partial.
- SEARCH -> VERIFY when h_meas equals H_TOTAL and v_meas equals V_TOTAL.
- VERIFY -> LOCKED on a second consecutive match; VERIFY -> SEARCH on a mismatch.
REQ-031 In LOCKED, an h_meas mismatch at any hsync edge or a v_meas mismatch at a vsync edge SHALL move the FSM to SEARCH and increment err_cnt_o, saturating at 255.
REQ-032 locked_o SHALL be high only in LOCKED; on lock loss pix_valid_o SHALL be low from the same cycle in which locked_o falls.
REQ-033 A gap in pix_en_i SHALL neither advance counters nor generate edges, and SHALL NOT by itself cause a lock loss.

Reset
REQ-034 On reset, all counters, h_meas_o, v_meas_o, err_cnt_o, pix_valid_o, frame_start_o and locked_o SHALL be 0, and x_o, y_o and rgb_o SHALL be 0.
REQ-035 On reset the FSM SHALL enter INIT and the input pipeline SHALL hold the inactive sync level.
REQ-036 A reset mid-frame SHALL discard all lock state, so relock requires two further full matching frames after the INIT frame.

Structure
REQ-037 The timing defaults, the RGB565 colour constants and the FSM state encoding SHALL live in a shared vga_pkg, also used by vgaDriver.
REQ-038 The hcnt/vcnt counting and measurement logic SHALL be a sub-module vga_sync_counter; the FSM, active-region decode and output registers stay top-level.

Verification
REQ-039 Feed vgaDriver 640x480 output to the decoder: locked_o rises at the third vsync edge, h_meas=800, v_meas=525, err_cnt=0.
REQ-040 While locked, input (0,0)=F,0,0: rgb_o=F800 with frame_start_o=1; input (639,479)=F,F,F: rgb_o=FFFF, x=639, y=479; each 3 cycles after its strobe.
REQ-041 While locked, shorten one line to 799 pixels: locked_o falls at that hsync edge, err_cnt=1, and relock occurs after two good frames.
REQ-042 Hold pix_en_i low for 5 cycles mid-line: hcnt and x_o continue without skip, and locked_o stays high.
REQ-043 Assert reset at frame line 200: all outputs 0 on the next cycle, and locked_o returns only after INIT plus two matching frames.
REQ-044 Run with SYNC_POL=1 and inverted syncs: behaviour identical to REQ-039.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA definitions for the sync decoder and vgaDriver.
// Contents:
//   - 640x480@60 timing defaults, counted in pixels (H) and lines (V)
//   - sync polarity default (0 = active-low)
//   - counter width and saturation limit shared by the measurement logic
//   - RGB565 colour constants and the RGB444 -> RGB565 packing helper
//   - encoding of the lock state machine
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_TOTAL_DEF  = 525;
    localparam int SYNC_POL_DEF = 0;

    localparam int                CNT_W   = 12;
    localparam logic [CNT_W-1:0]  CNT_MAX = 12'hFFF;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic [1:0] {
        LOCK_INIT   = 2'd0,
        LOCK_SEARCH = 2'd1,
        LOCK_VERIFY = 2'd2,
        LOCK_LOCKED = 2'd3
    } lock_state_e;

    // Increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : (v + 12'd1);
    endfunction

    // Widen 4-bit channels by replicating their MSBs into the new low bits.
    function automatic logic [15:0] rgb444_to_565(input logic [3:0] r,
                                                  input logic [3:0] g,
                                                  input logic [3:0] b);
        return {r, r[3], g, g[3:2], b, b[3]};
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Horizontal/vertical position counters and line/frame length measurement,
// driven by strobe-qualified, polarity-normalised sync samples.
// Ports:
//   SYS_CLK, reset         clock, synchronous active-high reset
//   strobe_i               pixel strobe (already pipelined)
//   hs_act_i, vs_act_i     1 when the sync sample is at its active level
//   hs_edge_o, vs_edge_o   leading edge detected on this strobe
//   hcnt_d_o, vcnt_d_o     position assigned to the current sample
//   h_meas_d_o, v_meas_d_o measurement values being loaded this cycle
//   h_meas_o, v_meas_o     registered last line length / frame length
// ---------------------------------------------------------------------------
module vga_sync_counter
    import vga_pkg::*;
(
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             strobe_i,
    input  logic             hs_act_i,
    input  logic             vs_act_i,
    output logic             hs_edge_o,
    output logic             vs_edge_o,
    output logic [CNT_W-1:0] hcnt_d_o,
    output logic [CNT_W-1:0] vcnt_d_o,
    output logic [CNT_W-1:0] h_meas_d_o,
    output logic [CNT_W-1:0] v_meas_d_o,
    output logic [CNT_W-1:0] h_meas_o,
    output logic [CNT_W-1:0] v_meas_o
);

    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d;
    logic [CNT_W-1:0] v_meas_q, v_meas_d;
    logic             hs_edge_s, vs_edge_s;

    // Edge detection and next-count / next-measurement computation.
    always_comb begin
        // Edges compare against the previous strobed sample, so gaps in the
        // strobe can never fabricate a transition.
        hs_edge_s = strobe_i & hs_act_i & ~hs_prev_q;
        vs_edge_s = strobe_i & vs_act_i & ~vs_prev_q;

        if (strobe_i) begin
            hs_prev_d = hs_act_i;
            vs_prev_d = vs_act_i;
        end else begin
            hs_prev_d = hs_prev_q;
            vs_prev_d = vs_prev_q;
        end

        if (!strobe_i) begin
            hcnt_d = hcnt_q;
        end else if (hs_edge_s) begin
            hcnt_d = 12'd0;
        end else begin
            hcnt_d = sat_inc(hcnt_q);
        end

        if (hs_edge_s) begin
            h_meas_d = sat_inc(hcnt_q);
        end else begin
            h_meas_d = h_meas_q;
        end

        // A vsync edge wins over a coincident hsync edge: the new frame
        // starts at line 0 rather than line 1.
        if (vs_edge_s) begin
            vcnt_d   = 12'd0;
            v_meas_d = sat_inc(vcnt_q);
        end else if (hs_edge_s) begin
            vcnt_d   = sat_inc(vcnt_q);
            v_meas_d = v_meas_q;
        end else begin
            vcnt_d   = vcnt_q;
            v_meas_d = v_meas_q;
        end
    end

    // Counter, measurement and previous-sync state registers.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            hcnt_q    <= 12'd0;
            vcnt_q    <= 12'd0;
            h_meas_q  <= 12'd0;
            v_meas_q  <= 12'd0;
        end else begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            h_meas_q  <= h_meas_d;
            v_meas_q  <= v_meas_d;
        end
    end

    assign hs_edge_o  = hs_edge_s;
    assign vs_edge_o  = vs_edge_s;
    assign hcnt_d_o   = hcnt_d;
    assign vcnt_d_o   = vcnt_d;
    assign h_meas_d_o = h_meas_d;
    assign v_meas_d_o = v_meas_d;
    assign h_meas_o   = h_meas_q;
    assign v_meas_o   = v_meas_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Recovers pixel coordinates from an incoming VGA stream, checks the timing
// against the configured mode and emits RGB565 pixels once locked.
// Ports:
//   SYS_CLK, reset                 clock, synchronous active-high reset
//   pix_en_i                       one pulse per incoming pixel
//   hsync_i, vsync_i               incoming syncs, active level = SYNC_POL
//   red_i, green_i, blue_i         incoming 4-bit colour
//   pix_valid_o                    decoded active pixel present
//   x_o, y_o                       active-area coordinates
//   rgb_o                          RGB565 pixel
//   frame_start_o                  pulse with the pixel at (0,0)
//   locked_o                       timing matches the parameters
//   h_meas_o, v_meas_o             last line length / frame length
//   err_cnt_o                      saturating count of lock losses
// Pixel outputs appear three cycles after the strobe that carried them.
// ---------------------------------------------------------------------------
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF
) (
    input  logic        SYS_CLK,
    input  logic        reset,
    input  logic        pix_en_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [3:0]  red_i,
    input  logic [3:0]  green_i,
    input  logic [3:0]  blue_i,
    output logic        pix_valid_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [15:0] rgb_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic [11:0] h_meas_o,
    output logic [11:0] v_meas_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic             SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] H_START  = 12'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_END    = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START  = 12'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_END    = 12'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_TOT_W  = 12'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT_W  = 12'(V_TOTAL);

    logic [1:0]       en_pipe_q;
    logic [1:0]       hs_pipe_q;
    logic [1:0]       vs_pipe_q;
    logic [11:0]      col_pipe_q [2];

    logic             strobe_s, hs_act_s, vs_act_s;
    logic             hs_edge_s, vs_edge_s;
    logic [CNT_W-1:0] hcnt_d_s, vcnt_d_s, h_meas_d_s, v_meas_d_s;

    lock_state_e      state_q, state_d;
    logic             h_bad_q, h_bad_d;
    logic [7:0]       err_q, err_d;
    logic             h_ok_s, v_ok_s, frame_ok_s, lost_s;

    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             locked_q, locked_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [15:0]      rgb_q, rgb_d;
    logic             h_in_s, v_in_s;

    // Two-stage input pipeline; syncs rest at their inactive level in reset.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            en_pipe_q     <= 2'b00;
            hs_pipe_q     <= {2{~SYNC_ACT}};
            vs_pipe_q     <= {2{~SYNC_ACT}};
            col_pipe_q[0] <= 12'h000;
            col_pipe_q[1] <= 12'h000;
        end else begin
            en_pipe_q     <= {en_pipe_q[0], pix_en_i};
            hs_pipe_q     <= {hs_pipe_q[0], hsync_i};
            vs_pipe_q     <= {vs_pipe_q[0], vsync_i};
            col_pipe_q[0] <= {red_i, green_i, blue_i};
            col_pipe_q[1] <= col_pipe_q[0];
        end
    end

    assign strobe_s = en_pipe_q[1];
    assign hs_act_s = (hs_pipe_q[1] == SYNC_ACT);
    assign vs_act_s = (vs_pipe_q[1] == SYNC_ACT);

    vga_sync_counter u_counter (
        .SYS_CLK    (SYS_CLK),
        .reset      (reset),
        .strobe_i   (strobe_s),
        .hs_act_i   (hs_act_s),
        .vs_act_i   (vs_act_s),
        .hs_edge_o  (hs_edge_s),
        .vs_edge_o  (vs_edge_s),
        .hcnt_d_o   (hcnt_d_s),
        .vcnt_d_o   (vcnt_d_s),
        .h_meas_d_o (h_meas_d_s),
        .v_meas_d_o (v_meas_d_s),
        .h_meas_o   (h_meas_o),
        .v_meas_o   (v_meas_o)
    );

    // Lock FSM next state, per-frame line check and error counter.
    always_comb begin
        state_d = state_q;
        lost_s  = 1'b0;
        h_ok_s  = (h_meas_d_s == H_TOT_W);
        v_ok_s  = (v_meas_d_s == V_TOT_W);

        // A frame only counts as matching if every line in it matched, not
        // just the last one seen at the vsync edge.
        frame_ok_s = v_ok_s && h_ok_s && !h_bad_q;

        if (vs_edge_s) begin
            h_bad_d = 1'b0;
        end else if (hs_edge_s && !h_ok_s) begin
            h_bad_d = 1'b1;
        end else begin
            h_bad_d = h_bad_q;
        end

        case (state_q)
            LOCK_INIT: begin
                if (vs_edge_s) begin
                    state_d = LOCK_SEARCH;
                end else begin
                    state_d = state_q;
                end
            end
            LOCK_SEARCH: begin
                if (vs_edge_s && frame_ok_s) begin
                    state_d = LOCK_VERIFY;
                end else begin
                    state_d = state_q;
                end
            end
            LOCK_VERIFY: begin
                if (vs_edge_s) begin
                    state_d = frame_ok_s ? LOCK_LOCKED : LOCK_SEARCH;
                end else begin
                    state_d = state_q;
                end
            end
            LOCK_LOCKED: begin
                if ((hs_edge_s && !h_ok_s) || (vs_edge_s && !v_ok_s)) begin
                    state_d = LOCK_SEARCH;
                    lost_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = LOCK_INIT;
            end
        endcase

        if (lost_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
        locked_d = (state_d == LOCK_LOCKED);
    end

    // Active-region decode; using state_d makes valid drop with locked_o.
    always_comb begin
        h_in_s  = (hcnt_d_s >= H_START) && (hcnt_d_s < H_END);
        v_in_s  = (vcnt_d_s >= V_START) && (vcnt_d_s < V_END);
        valid_d = strobe_s && h_in_s && v_in_s && (state_d == LOCK_LOCKED);
        if (valid_d) begin
            x_d   = 10'(hcnt_d_s - H_START);
            y_d   = 10'(vcnt_d_s - V_START);
            rgb_d = rgb444_to_565(col_pipe_q[1][11:8], col_pipe_q[1][7:4],
                                  col_pipe_q[1][3:0]);
            fs_d  = (hcnt_d_s == H_START) && (vcnt_d_s == V_START);
        end else begin
            x_d   = x_q;
            y_d   = y_q;
            rgb_d = rgb_q;
            fs_d  = 1'b0;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            state_q  <= LOCK_INIT;
            h_bad_q  <= 1'b0;
            err_q    <= 8'd0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            rgb_q    <= RGB565_BLACK;
        end else begin
            state_q  <= state_d;
            h_bad_q  <= h_bad_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pix_valid_o   = valid_q;
    assign frame_start_o = fs_q;
    assign locked_o      = locked_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign rgb_o         = rgb_q;
    assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Directed scoreboard bench using a reduced video mode (16x10 total,
// 8x4 active) so whole frames run quickly. A second instance with
// SYNC_POL=1 receives inverted syncs and must track lock identically.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HA  = 8;
    localparam int HS  = 2;
    localparam int HB  = 2;
    localparam int HT  = 16;
    localparam int VA  = 4;
    localparam int VS  = 1;
    localparam int VB  = 2;
    localparam int VT  = 10;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic        SYS_CLK = 1'b0;
    logic        reset;
    logic        pix_en_i;
    logic        hsync_i, vsync_i;
    logic        hsync_inv, vsync_inv;
    logic [3:0]  red_i, green_i, blue_i;

    logic        valid_0, fs_0, locked_0;
    logic [9:0]  x_0, y_0;
    logic [15:0] rgb_0;
    logic [11:0] hm_0, vm_0;
    logic [7:0]  err_0;

    logic        valid_1, fs_1, locked_1;
    logic [9:0]  x_1, y_1;
    logic [15:0] rgb_1;
    logic [11:0] hm_1, vm_1;
    logic [7:0]  err_1;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] rgb;
        logic        fs;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   exp_locked;

    always #5 SYS_CLK = ~SYS_CLK;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    assign hsync_inv = ~hsync_i;
    assign vsync_inv = ~vsync_i;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .SYNC_POL(0)
    ) dut0 (
        .SYS_CLK(SYS_CLK), .reset(reset), .pix_en_i(pix_en_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .pix_valid_o(valid_0), .x_o(x_0), .y_o(y_0), .rgb_o(rgb_0),
        .frame_start_o(fs_0), .locked_o(locked_0),
        .h_meas_o(hm_0), .v_meas_o(vm_0), .err_cnt_o(err_0)
    );

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .SYNC_POL(1)
    ) dut1 (
        .SYS_CLK(SYS_CLK), .reset(reset), .pix_en_i(pix_en_i),
        .hsync_i(hsync_inv), .vsync_i(vsync_inv),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .pix_valid_o(valid_1), .x_o(x_1), .y_o(y_1), .rgb_o(rgb_1),
        .frame_start_o(fs_1), .locked_o(locked_1),
        .h_meas_o(hm_1), .v_meas_o(vm_1), .err_cnt_o(err_1)
    );

    // Monitor: every presented pixel must match the oldest expectation.
    always @(negedge SYS_CLK) begin
        if (valid_0 === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_pixel actual x=%0d y=%0d rgb=%h required no pixel",
                         x_0, y_0, rgb_0);
            end else begin
                mon_e = sb_q.pop_front();
                if (x_0 !== mon_e.x || y_0 !== mon_e.y || rgb_0 !== mon_e.rgb ||
                    fs_0 !== mon_e.fs || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL pixel actual x=%0d y=%0d rgb=%h fs=%0b cyc=%0d required x=%0d y=%0d rgb=%h fs=%0b cyc=%0d",
                             x_0, y_0, rgb_0, fs_0, cyc,
                             mon_e.x, mon_e.y, mon_e.rgb, mon_e.fs, mon_e.cyc);
                end
            end
        end else if (fs_0 === 1'b1) begin
            total++;
            bad++;
            $display("FAIL frame_start_alone actual fs=1 required fs=0 without pixel");
        end
    end

    function automatic logic [15:0] pack565(input logic [3:0] r,
                                            input logic [3:0] g,
                                            input logic [3:0] b);
        return {r, r[3], g, g[3:2], b, b[3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        pix_en_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_pixel(input int h, input int v);
        logic [3:0] r, g, b;
        exp_t       e;
        bit         act;
        r     = 4'(h);
        g     = 4'(v);
        b     = 4'(h + v);
        e.rgb = pack565(r, g, b);
        if (h == HST && v == VST) begin
            r = 4'hF; g = 4'h0; b = 4'h0;
            e.rgb = 16'hF800;
        end else if (h == HST + HA - 1 && v == VST + VA - 1) begin
            r = 4'hF; g = 4'hF; b = 4'hF;
            e.rgb = 16'hFFFF;
        end
        pix_en_i = 1'b1;
        hsync_i  = (h < HS) ? 1'b0 : 1'b1;
        vsync_i  = (v < VS) ? 1'b0 : 1'b1;
        red_i    = r;
        green_i  = g;
        blue_i   = b;
        act = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
        if (exp_locked && act) begin
            e.x   = 10'(h - HST);
            e.y   = 10'(v - VST);
            e.fs  = (h == HST) && (v == VST);
            e.cyc = cyc + 3;
            sb_q.push_back(e);
        end
        tick();
    endtask

    // Lines v_first..v_last; bad_line is one pixel short (lock expected to
    // drop at the next hsync edge); gap_line gets a 5-cycle strobe gap.
    task automatic send_lines(input int v_first, input int v_last,
                              input int bad_line, input int gap_line,
                              input bit lock0);
        exp_locked = lock0;
        for (int v = v_first; v <= v_last; v++) begin
            if (bad_line >= 0 && v == bad_line + 1) exp_locked = 1'b0;
            for (int h = 0; h < ((v == bad_line) ? HT - 1 : HT); h++) begin
                if (v == gap_line && h == HST + 3) idle(5);
                send_pixel(h, v);
            end
        end
    endtask

    task automatic drain();
        idle(5);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic status(input bit lk, input logic [7:0] err);
        check("locked_pol0", {31'd0, locked_0}, {31'd0, lk});
        check("locked_pol1", {31'd0, locked_1}, {31'd0, lk});
        check("err_pol0", {24'd0, err_0}, {24'd0, err});
        check("err_pol1", {24'd0, err_1}, {24'd0, err});
    endtask

    task automatic meas();
        check("h_meas_pol0", {20'd0, hm_0}, 32'd16);
        check("v_meas_pol0", {20'd0, vm_0}, 32'd10);
        check("h_meas_pol1", {20'd0, hm_1}, 32'd16);
        check("v_meas_pol1", {20'd0, vm_1}, 32'd10);
    endtask

    task automatic zero_outputs();
        check("rst_valid",  {31'd0, valid_0}, 32'd0);
        check("rst_fs",     {31'd0, fs_0}, 32'd0);
        check("rst_locked", {31'd0, locked_0}, 32'd0);
        check("rst_x",      {22'd0, x_0}, 32'd0);
        check("rst_y",      {22'd0, y_0}, 32'd0);
        check("rst_rgb",    {16'd0, rgb_0}, 32'd0);
        check("rst_hmeas",  {20'd0, hm_0}, 32'd0);
        check("rst_vmeas",  {20'd0, vm_0}, 32'd0);
        check("rst_err",    {24'd0, err_0}, 32'd0);
        check("rst_locked_pol1", {31'd0, locked_1}, 32'd0);
        check("rst_err_pol1",    {24'd0, err_1}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; pix_en_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
        red_i = 4'h0; green_i = 4'h0; blue_i = 4'h0; exp_locked = 1'b0;
        repeat (3) tick();
        zero_outputs();
        reset = 1'b0;
        tick();

        // Acquire: INIT frame, match, second match -> locked at third edge.
        send_lines(0, VT - 1, -1, -1, 1'b0);
        send_lines(0, VT - 1, -1, -1, 1'b0);
        drain();
        status(1'b0, 8'd0);
        meas();
        send_lines(0, VT - 1, -1, -1, 1'b1);
        drain();
        status(1'b1, 8'd0);
        meas();

        // Strobe gap mid-line: no skip, lock held.
        send_lines(0, VT - 1, -1, VST + 1, 1'b1);
        drain();
        status(1'b1, 8'd0);

        // Short line: lock lost at next hsync edge, relock after two good frames.
        send_lines(0, VT - 1, 5, -1, 1'b1);
        drain();
        status(1'b0, 8'd1);
        send_lines(0, VT - 1, -1, -1, 1'b0);
        send_lines(0, VT - 1, -1, -1, 1'b0);
        drain();
        status(1'b0, 8'd1);
        send_lines(0, VT - 1, -1, -1, 1'b1);
        drain();
        status(1'b1, 8'd1);
        meas();

        // Reset mid-frame, then INIT frame plus two matching frames.
        send_lines(0, 4, -1, -1, 1'b1);
        drain();
        reset = 1'b1;
        tick();
        zero_outputs();
        tick();
        reset = 1'b0;
        send_lines(5, VT - 1, -1, -1, 1'b0);
        send_lines(0, VT - 1, -1, -1, 1'b0);
        send_lines(0, VT - 1, -1, -1, 1'b0);
        drain();
        status(1'b0, 8'd0);
        send_lines(0, VT - 1, -1, -1, 1'b1);
        drain();
        status(1'b1, 8'd0);
        meas();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
